// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 8x8 unsigned shift-and-add multiplier that borrows
// the shared combinational alu. Alternates ADD and SHL opcodes so the alu sees
// an opcode change every busy cycle. Returns low 8 product bits plus overflow.
module alu_mul_seq #(
  parameter int          N_BITS  = 8,
  parameter logic [2:0]  OP_ADD  = 3'b000,
  parameter logic [2:0]  OP_SHL  = 3'b011,
  parameter logic [2:0]  OP_IDLE = 3'b110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       ovf,
  output logic [2:0] alu_op,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  input  logic [7:0] alu_result
);

  localparam logic [2:0] LAST_IDX = 3'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SHL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [2:0] idx_q, idx_d;
  logic       lost_q, lost_d;       // multiplicand has shifted a 1 out of bit 7
  logic       ovf_run_q, ovf_run_d; // overflow seen so far in the running op
  logic [7:0] product_q, product_d;
  logic       ovf_q, ovf_d;

  logic       cur_bit;
  assign cur_bit = mplier_q[idx_q];

  // alu drive and status decoded purely from registered state
  always_comb begin
    alu_op    = OP_IDLE;
    alu_data1 = 8'h00;
    alu_data2 = 8'h00;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_ADD: begin
        alu_op    = OP_ADD;
        alu_data1 = acc_q;
        alu_data2 = cur_bit ? mcand_q : 8'h00;
      end
      S_SHL: begin
        alu_op    = OP_SHL;
        alu_data1 = mcand_q;
      end
      default: ;
    endcase
  end

  // next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    idx_d     = idx_q;
    lost_d    = lost_q;
    ovf_run_d = ovf_run_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ADD;
          mcand_d   = a;
          mplier_d  = b;
          acc_d     = 8'h00;
          idx_d     = 3'd0;
          lost_d    = 1'b0;
          ovf_run_d = 1'b0;
        end
      end
      S_ADD: begin
        acc_d = alu_result;
        // a wrapped add, or a set bit meeting a multiplicand that already
        // lost its top bit, both mean the true product exceeds 8 bits
        if (cur_bit && ((alu_result < acc_q) || lost_q))
          ovf_run_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d   = S_DONE;
          product_d = alu_result;
          ovf_d     = ovf_run_d;
        end else begin
          state_d = S_SHL;
        end
      end
      S_SHL: begin
        mcand_d = alu_result;
        lost_d  = lost_q | mcand_q[7];
        idx_d   = idx_q + 3'd1;
        state_d = S_ADD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register, async clear discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= 8'h00;
      mcand_q   <= 8'h00;
      mplier_q  <= 8'h00;
      idx_q     <= 3'd0;
      lost_q    <= 1'b0;
      ovf_run_q <= 1'b0;
      product_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      idx_q     <= idx_d;
      lost_q    <= lost_d;
      ovf_run_q <= ovf_run_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign product = product_q;
  assign ovf     = ovf_q;

endmodule
